// File: rtl/led_pkg.sv
// Shared mode encodings and width helper for the port LED activity driver.
package led_pkg;

  localparam logic [1:0] LED_MODE_ACT    = 2'b00;
  localparam logic [1:0] LED_MODE_OFF    = 2'b01;
  localparam logic [1:0] LED_MODE_ON     = 2'b10;
  localparam logic [1:0] LED_MODE_LOCATE = 2'b11;

  // Counter width for a range of n values, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_activity_channel.sv
// One activity LED channel: latches events and darkens the LED for
// HOLD_PERIODS blink high-phases, aligned to the shared blink strobes.
module led_activity_channel
  import led_pkg::*;
#(
  parameter int HOLD_PERIODS = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic link,
  input  logic evt,
  input  logic rise_stb,
  input  logic fall_stb,
  output logic dark
);

  localparam int HOLD_W = cnt_width(HOLD_PERIODS + 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_PERIODS - 1);

  logic              pending;
  logic [HOLD_W-1:0] hold_cnt;

  always_ff @(posedge clk) begin
    if (rst || !link) begin
      pending  <= 1'b0;
      hold_cnt <= '0;
      dark     <= 1'b0;
    end else begin
      if (evt) pending <= 1'b1;
      if (rise_stb) begin
        if (pending) begin
          dark     <= 1'b1;
          hold_cnt <= HOLD_INIT;
        end else if (hold_cnt != '0) begin
          dark     <= 1'b1;
          hold_cnt <= hold_cnt - 1'b1;
        end
        // An event coinciding with the rise is deferred to the next period.
        if (!evt) pending <= 1'b0;
      end
      if (fall_stb) dark <= 1'b0;
    end
  end

endmodule

// File: rtl/led_activity_array.sv
// Multi-port TX/RX activity LED driver with internal blink prescaler and
// per-port mode override (activity / off / on / locate).
module led_activity_array
  import led_pkg::*;
#(
  parameter int NUM_PORTS         = 4,
  parameter int BLINK_HALF_CYCLES = 6250000,
  parameter int HOLD_PERIODS      = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_PORTS-1:0]   has_link,
  input  logic [NUM_PORTS-1:0]   on_frame_sent,
  input  logic [NUM_PORTS-1:0]   on_frame_received,
  input  logic [2*NUM_PORTS-1:0] mode,
  output logic [2*NUM_PORTS-1:0] led,
  output logic                   blink_out
);

  localparam int CNT_W = cnt_width(BLINK_HALF_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_HALF_CYCLES - 1);

  logic [CNT_W-1:0]       cnt;
  logic                   phase;
  logic                   tc;
  logic                   rise_stb;
  logic                   fall_stb;
  logic [2*NUM_PORTS-1:0] dark;

  assign tc       = (cnt == CNT_LAST);
  // Strobes mark the cycle whose closing edge flips the phase, so channel
  // darkening lines up exactly with the high phase.
  assign rise_stb = tc & ~phase;
  assign fall_stb = tc & phase;
  assign blink_out = phase;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (tc) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  for (genvar c = 0; c < 2*NUM_PORTS; c++) begin : g_ch
    led_activity_channel #(
      .HOLD_PERIODS(HOLD_PERIODS)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .link    (has_link[c/2]),
      .evt     ((c % 2 == 0) ? on_frame_sent[c/2] : on_frame_received[c/2]),
      .rise_stb(rise_stb),
      .fall_stb(fall_stb),
      .dark    (dark[c])
    );
  end

  always_comb begin
    led = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      case (mode[2*p +: 2])
        LED_MODE_ACT: led[2*p +: 2] = {2{has_link[p]}} & ~dark[2*p +: 2];
        LED_MODE_OFF: led[2*p +: 2] = 2'b00;
        LED_MODE_ON:  led[2*p +: 2] = 2'b11;
        default:      led[2*p +: 2] = {2{phase}};
      endcase
    end
  end

endmodule

// File: tb/tb_led_activity_array.sv
// Bench for led_activity_array: constant vector table, hand-written corner
// sequences and a randomized run against a period-based reference model.
module tb_led_activity_array;

  localparam int NP   = 2;
  localparam int B    = 4;
  localparam int H    = 2;
  localparam int NCH  = 2*NP;
  localparam int MAXP = 512;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NP-1:0] has_link = '0;
  logic [NP-1:0] on_frame_sent = '0;
  logic [NP-1:0] on_frame_received = '0;
  logic [NCH-1:0] mode = '0;
  logic [NCH-1:0] led;
  logic           blink_out;

  always #5 clk = ~clk;

  led_activity_array #(
    .NUM_PORTS(NP),
    .BLINK_HALF_CYCLES(B),
    .HOLD_PERIODS(H)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .has_link         (has_link),
    .on_frame_sent    (on_frame_sent),
    .on_frame_received(on_frame_received),
    .mode             (mode),
    .led              (led),
    .blink_out        (blink_out)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit mark [NCH][MAXP];   // mark[ch][k]: channel is dark in high period k

  typedef struct {
    logic [NP-1:0]  link;
    logic [NCH-1:0] md;
    logic [NCH-1:0] exp_led;
    logic           exp_blink;
  } vec_t;
  vec_t tbl [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // High period k covers cycles [2Bk+B, 2Bk+2B-1]; an event is shown from the
  // first high period whose preceding cycle lies strictly after the event.
  function automatic int target_period(input int t);
    return (t >= B-1) ? (t - B + 1) / (2*B) + 1 : 0;
  endfunction

  function automatic logic [NCH-1:0] model_led(input logic [NP-1:0] lk, input logic [NCH-1:0] md);
    logic [NCH-1:0] r;
    int ph;
    int per;
    bit dk;
    r   = '0;
    ph  = (cyc / B) % 2;
    per = cyc / (2*B);
    for (int ch = 0; ch < NCH; ch++) begin
      dk = (ph == 1) && (per < MAXP) && mark[ch][per];
      case (md[2*(ch/2) +: 2])
        2'b00:   r[ch] = lk[ch/2] & !dk;
        2'b01:   r[ch] = 1'b0;
        2'b10:   r[ch] = 1'b1;
        default: r[ch] = (ph == 1);
      endcase
    end
    return r;
  endfunction

  task automatic model_clear();
    for (int ch = 0; ch < NCH; ch++)
      for (int k = 0; k < MAXP; k++) mark[ch][k] = 1'b0;
  endtask

  task automatic model_update(input logic [NP-1:0] lk, input logic [NP-1:0] s, input logic [NP-1:0] r);
    int k;
    bit e;
    for (int ch = 0; ch < NCH; ch++) begin
      e = (ch % 2 == 0) ? s[ch/2] : r[ch/2];
      if (!lk[ch/2]) begin
        for (int j = 0; j < MAXP; j++) mark[ch][j] = 1'b0;
      end else if (e) begin
        k = target_period(cyc);
        for (int j = k; j < k + H; j++) if (j < MAXP) mark[ch][j] = 1'b1;
      end
    end
  endtask

  task automatic apply(input logic [NP-1:0] lk, input logic [NP-1:0] s,
                       input logic [NP-1:0] r, input logic [NCH-1:0] md);
    has_link = lk;
    on_frame_sent = s;
    on_frame_received = r;
    mode = md;
    #1;
    check("led_model", 32'(led), 32'(model_led(lk, md)));
    check("blink_model", 32'(blink_out), 32'((cyc / B) % 2));
    model_update(lk, s, r);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    on_frame_sent = '0;
    on_frame_received = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    model_clear();
  endtask

  task automatic idle_until(input int target, input logic [NP-1:0] lk, input logic [NCH-1:0] md);
    while (cyc < target) begin
      apply(lk, '0, '0, md);
      tick();
    end
  endtask

  logic [NP-1:0]  cur_link;
  logic [NCH-1:0] cur_mode;
  logic [NP-1:0]  rs;
  logic [NP-1:0]  rr;

  initial begin
    tbl[0]  = '{2'b01, 4'b0100, 4'b0011, 1'b0};
    tbl[1]  = '{2'b01, 4'b1000, 4'b1111, 1'b0};
    tbl[2]  = '{2'b01, 4'b1100, 4'b0011, 1'b0};
    tbl[3]  = '{2'b01, 4'b1100, 4'b0011, 1'b0};
    tbl[4]  = '{2'b01, 4'b1100, 4'b1111, 1'b1};
    tbl[5]  = '{2'b01, 4'b0000, 4'b0011, 1'b1};
    tbl[6]  = '{2'b01, 4'b0000, 4'b0011, 1'b1};
    tbl[7]  = '{2'b01, 4'b0000, 4'b0011, 1'b1};
    tbl[8]  = '{2'b01, 4'b0011, 4'b0000, 1'b0};
    tbl[9]  = '{2'b01, 4'b0001, 4'b0000, 1'b0};
    tbl[10] = '{2'b01, 4'b0010, 4'b0011, 1'b0};
    tbl[11] = '{2'b01, 4'b0000, 4'b0011, 1'b0};
    tbl[12] = '{2'b01, 4'b0011, 4'b0011, 1'b1};
    tbl[13] = '{2'b01, 4'b1111, 4'b1111, 1'b1};
    tbl[14] = '{2'b01, 4'b0000, 4'b0011, 1'b1};
    tbl[15] = '{2'b01, 4'b0000, 4'b0011, 1'b1};
    tbl[16] = '{2'b01, 4'b0000, 4'b0011, 1'b0};

    has_link = 2'b01;
    do_reset();
    do_reset();

    // Reset state, steady blink and mode mux on a link-down port
    for (int i = 0; i < 17; i++) begin
      apply(tbl[i].link, '0, '0, tbl[i].md);
      check($sformatf("tbl_led[%0d]", i), 32'(led), 32'(tbl[i].exp_led));
      check($sformatf("tbl_blink[%0d]", i), 32'(blink_out), 32'(tbl[i].exp_blink));
      tick();
    end

    // Single TX event in phase 0 darkens the next two high phases
    do_reset();
    idle_until(1, 2'b01, 4'b0000);
    apply(2'b01, 2'b01, 2'b00, 4'b0000); tick();
    idle_until(5, 2'b01, 4'b0000);
    apply(2'b01, '0, '0, 4'b0000); check("tx_dark_p0", 32'(led), 32'h2); tick();
    idle_until(9, 2'b01, 4'b0000);
    apply(2'b01, '0, '0, 4'b0000); check("tx_low_lit", 32'(led), 32'h3); tick();
    idle_until(13, 2'b01, 4'b0000);
    apply(2'b01, '0, '0, 4'b0000); check("tx_dark_p1", 32'(led), 32'h2); tick();
    idle_until(21, 2'b01, 4'b0000);
    apply(2'b01, '0, '0, 4'b0000); check("tx_done_p2", 32'(led), 32'h3); tick();

    // RX event exactly in the rise cycle is deferred by one period
    do_reset();
    idle_until(3, 2'b01, 4'b0000);
    apply(2'b01, 2'b00, 2'b01, 4'b0000); tick();
    idle_until(5, 2'b01, 4'b0000);
    apply(2'b01, '0, '0, 4'b0000); check("rx_defer_p0", 32'(led), 32'h3); tick();
    idle_until(13, 2'b01, 4'b0000);
    apply(2'b01, '0, '0, 4'b0000); check("rx_dark_p1", 32'(led), 32'h1); tick();
    idle_until(21, 2'b01, 4'b0000);
    apply(2'b01, '0, '0, 4'b0000); check("rx_dark_p2", 32'(led), 32'h1); tick();
    idle_until(29, 2'b01, 4'b0000);
    apply(2'b01, '0, '0, 4'b0000); check("rx_done_p3", 32'(led), 32'h3); tick();

    // Link drop while dark clears everything; restore mid high phase
    do_reset();
    idle_until(1, 2'b01, 4'b0000);
    apply(2'b01, 2'b01, 2'b00, 4'b0000); tick();
    idle_until(5, 2'b01, 4'b0000);
    apply(2'b00, '0, '0, 4'b0000); check("link_drop", 32'(led), 32'h0); tick();
    apply(2'b01, '0, '0, 4'b0000); check("link_restore", 32'(led), 32'h3); tick();
    idle_until(13, 2'b01, 4'b0000);
    apply(2'b01, '0, '0, 4'b0000); check("link_no_stale", 32'(led), 32'h3); tick();

    // Reset mid high phase with a TX event still pending
    do_reset();
    idle_until(4, 2'b01, 4'b0000);
    apply(2'b01, 2'b01, 2'b00, 4'b0000); tick();
    do_reset();
    apply(2'b01, '0, '0, 4'b0000); check("rst_blink", 32'(blink_out), 32'h0); tick();
    idle_until(3, 2'b01, 4'b0000);
    apply(2'b01, '0, '0, 4'b0000); check("rst_pre_rise", 32'(blink_out), 32'h0); tick();
    apply(2'b01, '0, '0, 4'b0000);
    check("rst_rise", 32'(blink_out), 32'h1);
    check("rst_no_pending", 32'(led), 32'h3);
    tick();
    idle_until(12, 2'b01, 4'b0000);
    apply(2'b01, '0, '0, 4'b0000); check("rst_no_hold", 32'(led), 32'h3); tick();

    // Randomized traffic, link flaps, mode changes and occasional resets
    do_reset();
    cur_link = 2'b11;
    cur_mode = '0;
    for (int n = 0; n < 3000; n++) begin
      if (n % 700 == 699) do_reset();
      if ($urandom_range(0, 31) == 0) cur_link[$urandom_range(0, NP-1)] ^= 1'b1;
      if ($urandom_range(0, 29) == 0) begin
        int pp;
        pp = $urandom_range(0, NP-1);
        cur_mode[2*pp +: 2] = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(0, 3));
      end
      rs = NP'($urandom() & $urandom() & $urandom());
      rr = NP'($urandom() & $urandom() & $urandom());
      apply(cur_link, rs, rr, cur_mode);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
